// File: rtl/memory_arbiter.sv
// Multi-client memory arbiter: serialises NUM_PORTS valid/ready clients onto a
// single backing-memory port, one outstanding transaction at a time.
module memory_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             port_request,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_data,
  output logic [NUM_PORTS-1:0]             port_done,
  output logic [DATA_WIDTH-1:0]            port_read_data,
  output logic [NUM_PORTS-1:0]             port_stall,
  output logic                             mem_valid,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic                             mem_ready,
  input  logic                             mem_response_valid,
  input  logic [DATA_WIDTH-1:0]            mem_read_data
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_PORTS - 1);
  localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] pointer;
  logic [PTR_W-1:0] active_id;
  logic [PTR_W-1:0] winner_id;
  logic             any_request;

  // Scan from the pointer (round-robin) or from index 0 (fixed priority), wrapping.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    winner_id   = '0;
    any_request = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (PRIORITY_MODE != 0) ? k : int'(pointer) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PTR_W'(idx);
      if (!any_request && port_request[cand]) begin
        any_request = 1'b1;
        winner_id   = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pointer        <= '0;
      active_id      <= '0;
      port_done      <= '0;
      port_read_data <= '0;
      mem_valid      <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      port_done <= '0;
      case (state)
        IDLE: begin
          if (any_request) begin
            active_id      <= winner_id;
            mem_address    <= port_address[winner_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_write_data <= port_write_data[winner_id*DATA_WIDTH +: DATA_WIDTH];
            mem_write      <= port_write[winner_id];
            mem_valid      <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Writes also complete through mem_response_valid but keep the old read data.
          if (mem_response_valid) begin
            if (!mem_write) port_read_data <= mem_read_data;
            port_done <= PORT_ONE << active_id;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          if (PRIORITY_MODE == 0)
            pointer <= (active_id == LAST_ID) ? '0 : active_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port_stall = port_request & ~port_done;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three instances (2-port round-robin, 3-port
// round-robin, 3-port fixed priority) sharing one clock and reset.
module tb_memory_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic [2:0]  req     [3];
  logic [2:0]  wr      [3];
  logic [95:0] addr_f  [3];
  logic [95:0] wdata_f [3];
  logic        mready  [3];
  logic        mresp   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] mrdata  [3] = '{32'h0, 32'h0, 32'h0};
  int          delay   [3];

  logic [1:0]  a_done, a_stall;
  logic [2:0]  b_done, b_stall, c_done, c_stall;
  logic [31:0] a_rdata, b_rdata, c_rdata;
  logic        a_mvalid, b_mvalid, c_mvalid, a_mwrite, b_mwrite, c_mwrite;
  logic [31:0] a_maddr, b_maddr, c_maddr, a_mwdata, b_mwdata, c_mwdata;

  logic [2:0]  done_v   [3];
  logic [2:0]  stall_v  [3];
  logic [31:0] rdata_v  [3];
  logic [31:0] maddr_v  [3];
  logic [31:0] mwdata_v [3];
  logic        mvalid_v [3];
  logic        mwrite_v [3];

  assign done_v[0]   = {1'b0, a_done};   assign done_v[1]   = b_done;   assign done_v[2]   = c_done;
  assign stall_v[0]  = {1'b0, a_stall};  assign stall_v[1]  = b_stall;  assign stall_v[2]  = c_stall;
  assign rdata_v[0]  = a_rdata;          assign rdata_v[1]  = b_rdata;  assign rdata_v[2]  = c_rdata;
  assign maddr_v[0]  = a_maddr;          assign maddr_v[1]  = b_maddr;  assign maddr_v[2]  = c_maddr;
  assign mwdata_v[0] = a_mwdata;         assign mwdata_v[1] = b_mwdata; assign mwdata_v[2] = c_mwdata;
  assign mvalid_v[0] = a_mvalid;         assign mvalid_v[1] = b_mvalid; assign mvalid_v[2] = c_mvalid;
  assign mwrite_v[0] = a_mwrite;         assign mwrite_v[1] = b_mwrite; assign mwrite_v[2] = c_mwrite;

  memory_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .port_request(req[0][1:0]), .port_write(wr[0][1:0]),
    .port_address(addr_f[0][63:0]), .port_write_data(wdata_f[0][63:0]),
    .port_done(a_done), .port_read_data(a_rdata), .port_stall(a_stall),
    .mem_valid(a_mvalid), .mem_write(a_mwrite), .mem_address(a_maddr), .mem_write_data(a_mwdata),
    .mem_ready(mready[0]), .mem_response_valid(mresp[0]), .mem_read_data(mrdata[0]));

  memory_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .port_request(req[1]), .port_write(wr[1]),
    .port_address(addr_f[1]), .port_write_data(wdata_f[1]),
    .port_done(b_done), .port_read_data(b_rdata), .port_stall(b_stall),
    .mem_valid(b_mvalid), .mem_write(b_mwrite), .mem_address(b_maddr), .mem_write_data(b_mwdata),
    .mem_ready(mready[1]), .mem_response_valid(mresp[1]), .mem_read_data(mrdata[1]));

  memory_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_c (
    .clock(clock), .reset_n(reset_n),
    .port_request(req[2]), .port_write(wr[2]),
    .port_address(addr_f[2]), .port_write_data(wdata_f[2]),
    .port_done(c_done), .port_read_data(c_rdata), .port_stall(c_stall),
    .mem_valid(c_mvalid), .mem_write(c_mwrite), .mem_address(c_maddr), .mem_write_data(c_mwdata),
    .mem_ready(mready[2]), .mem_response_valid(mresp[2]), .mem_read_data(mrdata[2]));

  int compared = 0;
  int mismatched = 0;
  int proto_errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    if (a == 32'h84) return 32'hA5A5A5A5;
    return a ^ 32'h5A5A0000;
  endfunction

  // Memory: responds delay[k] extra cycles after acceptance; writes return junk data.
  int          cnt      [3] = '{0, 0, 0};
  logic [31:0] pend_addr[3] = '{32'h0, 32'h0, 32'h0};
  logic        pend_wr  [3] = '{1'b0, 1'b0, 1'b0};
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      mresp[k] <= 1'b0;
      if (mvalid_v[k] && mready[k]) begin
        if (delay[k] == 0) begin
          mresp[k]  <= 1'b1;
          mrdata[k] <= mwrite_v[k] ? 32'h0BADF00D : memf(maddr_v[k]);
          cnt[k]    <= 0;
        end else begin
          cnt[k]       <= delay[k];
          pend_addr[k] <= maddr_v[k];
          pend_wr[k]   <= mwrite_v[k];
        end
      end else if (cnt[k] > 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          mresp[k]  <= 1'b1;
          mrdata[k] <= pend_wr[k] ? 32'h0BADF00D : memf(pend_addr[k]);
        end
      end
    end
  end

  // A client must hold its request until its port_done.
  logic [2:0] hold [3] = '{3'b0, 3'b0, 3'b0};
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset_n) begin
        for (int i = 0; i < 3; i++)
          if (hold[k][i] && !req[k][i] && !done_v[k][i]) begin
            proto_errors <= proto_errors + 1;
            $display("[TB] FAIL protocol: dut %0d port %0d dropped request before done", k, i);
          end
        hold[k] <= req[k] & ~done_v[k];
      end else begin
        hold[k] <= 3'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input int p, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    req[k][p] = 1'b1;
    wr[k][p]  = w;
    addr_f[k][p*32 +: 32]  = a;
    wdata_f[k][p*32 +: 32] = d;
  endtask

  task automatic raiseRandom(input int k, input int p);
    applyStimulus(k, p, 1'($urandom_range(1, 0)), $urandom(), $urandom());
  endtask

  // Waits (bounded) for any port_done of instance k; captures the first issued request.
  task automatic waitDone(input int k, output int cyc, output logic [31:0] ia,
                          output logic iw, output logic [31:0] iwd);
    bit seen = 1'b0;
    bit found = 1'b0;
    cyc = 0; ia = '0; iw = 1'b0; iwd = '0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clock);
      cyc++;
      if (!seen && mvalid_v[k]) begin
        seen = 1'b1; ia = maddr_v[k]; iw = mwrite_v[k]; iwd = mwdata_v[k];
      end
      if (done_v[k] != 3'b0) found = 1'b1;
    end
    if (!found) begin
      compared++; mismatched++;
      $display("[TB] FAIL timeout: dut %0d got no port_done, expected one within 200 cycles", k);
    end
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) req[k] = 3'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reference model: picks the next winner from the request set and the rotation rule.
  task automatic randomRun(input int k, input int n, input bit fp, input int txns);
    int ptr = 0;
    int win, idx;
    bit found, issued;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] exp_addr, exp_wd;
    logic exp_wr;
    logic [2:0] oh;
    pulseReset();
    for (int t = 0; t < txns; t++) begin
      for (int i = 0; i < n; i++)
        if (!req[k][i] && $urandom_range(1, 0) == 1) raiseRandom(k, i);
      if (req[k] == 3'b0) raiseRandom(k, int'($urandom_range(n - 1, 0)));
      delay[k] = int'($urandom_range(2, 0));
      win = -1;
      for (int j = 0; j < n; j++) begin
        idx = fp ? j : (ptr + j) % n;
        if (win < 0 && req[k][idx]) win = idx;
      end
      exp_addr = addr_f[k][win*32 +: 32];
      exp_wd   = wdata_f[k][win*32 +: 32];
      exp_wr   = wr[k][win];
      found = 1'b0; issued = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        @(negedge clock);
        mready[k] = ($urandom_range(3, 0) != 0);
        if (mvalid_v[k] && mready[k] && !issued) begin
          issued = 1'b1;
          checkOutput("rand mem_address", maddr_v[k], exp_addr);
          checkOutput("rand mem_write", 32'(mwrite_v[k]), 32'(exp_wr));
          checkOutput("rand mem_write_data", mwdata_v[k], exp_wd);
        end
        if (done_v[k] != 3'b0) found = 1'b1;
      end
      if (!found) begin
        compared++; mismatched++;
        $display("[TB] FAIL rand timeout: dut %0d no port_done, expected port %0d", k, win);
        break;
      end
      oh = 3'b001 << win;
      checkOutput("rand port_done", 32'(done_v[k]), 32'(oh));
      if (!exp_wr) last_rd = memf(exp_addr);
      checkOutput("rand port_read_data", rdata_v[k], last_rd);
      if (!fp) ptr = (win + 1) % n;
      if ($urandom_range(1, 0) == 1) req[k][win] = 1'b0;
      else raiseRandom(k, win);
    end
    pulseReset();
    mready[k] = 1'b1;
    delay[k]  = 0;
  endtask

  typedef struct {
    int          port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  exp_done;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int cyc, cyc2;
    logic [31:0] ia, iwd;
    logic iw;
    bit bad;
    logic [2:0] rr_exp [4];
    int rr_lat [4];

    tbl[0] = '{port: 0, write: 1'b1, addr: 32'h80,   wdata: 32'h12345678, exp_done: 3'b001, exp_rdata: 32'hDEADBEEF};
    tbl[1] = '{port: 1, write: 1'b0, addr: 32'h84,   wdata: 32'h0,        exp_done: 3'b010, exp_rdata: 32'hA5A5A5A5};
    tbl[2] = '{port: 0, write: 1'b0, addr: 32'h10,   wdata: 32'h0,        exp_done: 3'b001, exp_rdata: 32'h5A5A0010};
    tbl[3] = '{port: 1, write: 1'b1, addr: 32'h84,   wdata: 32'hCAFEF00D, exp_done: 3'b010, exp_rdata: 32'h5A5A0010};
    tbl[4] = '{port: 1, write: 1'b0, addr: 32'h2000, wdata: 32'h0,        exp_done: 3'b010, exp_rdata: 32'h5A5A2000};
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_lat = '{3, 4, 4, 4};

    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 3'b0; wr[k] = 3'b0; addr_f[k] = '0; wdata_f[k] = '0;
      mready[k] = 1'b1; delay[k] = 0;
    end
    repeat (2) @(negedge clock);
    checkOutput("reset port_done", 32'(done_v[0]), 32'h0);
    checkOutput("reset port_read_data", rdata_v[0], 32'h0);
    checkOutput("reset mem_valid", 32'(mvalid_v[0]), 32'h0);
    checkOutput("reset mem_write", 32'(mwrite_v[0]), 32'h0);
    checkOutput("reset mem_address", maddr_v[0], 32'h0);
    checkOutput("reset mem_write_data", mwdata_v[0], 32'h0);
    checkOutput("reset b mem_valid", 32'(mvalid_v[1]), 32'h0);
    reset_n = 1'b1;

    // Single read at minimum latency.
    @(negedge clock);
    applyStimulus(0, 1, 1'b0, 32'h40, 32'h0);
    @(negedge clock);
    checkOutput("t1 mem_valid c1", 32'(mvalid_v[0]), 32'h1);
    checkOutput("t1 mem_address c1", maddr_v[0], 32'h40);
    checkOutput("t1 stall c1", 32'(stall_v[0]), 32'h2);
    @(negedge clock);
    checkOutput("t1 mem_valid c2", 32'(mvalid_v[0]), 32'h0);
    @(negedge clock);
    checkOutput("t1 port_done c3", 32'(done_v[0]), 32'h2);
    checkOutput("t1 read data c3", rdata_v[0], 32'hDEADBEEF);
    checkOutput("t1 stall c3", 32'(stall_v[0]), 32'h0);
    req[0][1] = 1'b0;

    for (int v = 0; v < 5; v++) begin
      @(negedge clock);
      applyStimulus(0, tbl[v].port, tbl[v].write, tbl[v].addr, tbl[v].wdata);
      waitDone(0, cyc, ia, iw, iwd);
      checkOutput($sformatf("vec%0d port_done", v), 32'(done_v[0]), 32'(tbl[v].exp_done));
      checkOutput($sformatf("vec%0d read data", v), rdata_v[0], tbl[v].exp_rdata);
      checkOutput($sformatf("vec%0d latency", v), 32'(cyc), 32'd3);
      checkOutput($sformatf("vec%0d mem_address", v), ia, tbl[v].addr);
      checkOutput($sformatf("vec%0d mem_write", v), 32'(iw), 32'(tbl[v].write));
      checkOutput($sformatf("vec%0d mem_write_data", v), iwd, tbl[v].wdata);
      req[0][tbl[v].port] = 1'b0;
    end

    // Backpressure: five ISSUE cycles with mem_ready low.
    @(negedge clock);
    mready[0] = 1'b0;
    applyStimulus(0, 0, 1'b1, 32'hC0, 32'h11223344);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      checkOutput($sformatf("bp mem_valid c%0d", i), 32'(mvalid_v[0]), 32'h1);
      checkOutput($sformatf("bp mem_address c%0d", i), maddr_v[0], 32'hC0);
      checkOutput($sformatf("bp mem_write_data c%0d", i), mwdata_v[0], 32'h11223344);
    end
    mready[0] = 1'b1;
    waitDone(0, cyc2, ia, iw, iwd);
    checkOutput("bp done cycle", 32'(6 + cyc2), 32'd8);
    checkOutput("bp port_done", 32'(done_v[0]), 32'h1);
    checkOutput("bp read data kept", rdata_v[0], 32'h5A5A2000);
    req[0][0] = 1'b0;

    // Reset mid-WAIT, with the pointer left at 1 beforehand.
    @(negedge clock);
    applyStimulus(0, 0, 1'b0, 32'h10, 32'h0);
    waitDone(0, cyc, ia, iw, iwd);
    checkOutput("rst pre port_done", 32'(done_v[0]), 32'h1);
    req[0][0] = 1'b0;
    @(negedge clock);
    delay[0] = 6;
    applyStimulus(0, 1, 1'b0, 32'h40, 32'h0);
    repeat (2) @(negedge clock);
    checkOutput("rst in WAIT mem_valid", 32'(mvalid_v[0]), 32'h0);
    @(negedge clock);
    reset_n = 1'b0;
    req[0][1] = 1'b0;
    #1;
    checkOutput("rst async read data", rdata_v[0], 32'h0);
    checkOutput("rst async port_done", 32'(done_v[0]), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (done_v[0] != 3'b0 || mvalid_v[0]) bad = 1'b1;
    end
    checkOutput("rst stale response ignored", 32'(bad), 32'h0);
    delay[0] = 0;
    applyStimulus(0, 0, 1'b0, 32'h10, 32'h0);
    applyStimulus(0, 1, 1'b0, 32'h84, 32'h0);
    waitDone(0, cyc, ia, iw, iwd);
    checkOutput("rst post first port_done", 32'(done_v[0]), 32'h1);
    checkOutput("rst post first data", rdata_v[0], 32'h5A5A0010);
    req[0][0] = 1'b0;
    waitDone(0, cyc, ia, iw, iwd);
    checkOutput("rst post second port_done", 32'(done_v[0]), 32'h2);
    checkOutput("rst post second data", rdata_v[0], 32'hA5A5A5A5);
    req[0][1] = 1'b0;

    // Round-robin contention on three ports.
    @(negedge clock);
    for (int p = 0; p < 3; p++) applyStimulus(1, p, 1'b0, 32'h100 + 32'(p * 4), 32'h0);
    for (int j = 0; j < 4; j++) begin
      waitDone(1, cyc, ia, iw, iwd);
      checkOutput($sformatf("rr%0d port_done", j), 32'(done_v[1]), 32'(rr_exp[j]));
      checkOutput($sformatf("rr%0d latency", j), 32'(cyc), 32'(rr_lat[j]));
      if (j == 0) checkOutput("rr0 stalls", 32'(stall_v[1]), 32'h6);
    end
    req[1][0] = 1'b0;
    waitDone(1, cyc, ia, iw, iwd);
    checkOutput("rr drain port1", 32'(done_v[1]), 32'h2);
    checkOutput("rr drain port1 data", rdata_v[1], memf(32'h104));
    req[1][1] = 1'b0;
    waitDone(1, cyc, ia, iw, iwd);
    checkOutput("rr drain port2", 32'(done_v[1]), 32'h4);
    req[1][2] = 1'b0;

    // Fixed priority: port 0 always beats port 2.
    @(negedge clock);
    applyStimulus(2, 0, 1'b0, 32'h200, 32'h0);
    applyStimulus(2, 2, 1'b0, 32'h208, 32'h0);
    for (int j = 0; j < 3; j++) begin
      waitDone(2, cyc, ia, iw, iwd);
      checkOutput($sformatf("fp%0d port_done", j), 32'(done_v[2]), 32'h1);
      checkOutput($sformatf("fp%0d port2 stall", j), 32'(stall_v[2][2]), 32'h1);
    end
    req[2][0] = 1'b0;
    waitDone(2, cyc, ia, iw, iwd);
    checkOutput("fp drain port2", 32'(done_v[2]), 32'h4);
    checkOutput("fp drain data", rdata_v[2], memf(32'h208));
    req[2][2] = 1'b0;

    randomRun(1, 3, 1'b0, 60);
    randomRun(2, 3, 1'b1, 60);
    randomRun(0, 2, 1'b0, 40);

    @(negedge clock);
    mismatched += proto_errors;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
